// File: rtl/serial_adder_ctrl.sv
// Slice-serial adder: one SLICE-bit adder reused over WIDTH/SLICE cycles behind valid/ready handshakes.
// Optional subtraction (A-B, two's complement) is built when the SAC_SUB_EN macro is defined.
module serial_adder_ctrl #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   generate
      if ((WIDTH % SLICE) != 0 || SLICE < 1) begin : g_bad_params
         $error("WIDTH must be a positive integer multiple of SLICE");
      end
   endgenerate

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic             carry_r;
   logic             cout_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] sum_r;
   logic [SLICE-1:0] a_sl;
   logic [SLICE-1:0] b_sl;
   logic [SLICE-1:0] b_eff;
   logic [SLICE:0]   slice_res;
   logic             preload;
   logic             accept;
   logic             last;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign accept    = in_valid && (state == IDLE);
   assign last      = (cnt == CW'(N - 1));

`ifdef SAC_SUB_EN
   logic sub_r;

   // Subtraction is A + ~B + 1; the +1 rides in through the carry preload.
   assign b_eff   = sub_r ? ~b_sl : b_sl;
   assign preload = sub ? 1'b1 : cin;

   always_ff @(posedge clk) begin
      if (accept) begin
         sub_r <= sub;
      end
   end
`else
   logic unused_sub;

   assign unused_sub = sub;
   assign b_eff      = b_sl;
   assign preload    = cin;
`endif

   // Select the operand slice addressed by the slice counter.
   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < N; k++) begin
         if (cnt == CW'(k)) begin
            a_sl = a_r[k*SLICE +: SLICE];
            b_sl = b_r[k*SLICE +: SLICE];
         end
      end
   end

   assign slice_res = {1'b0, a_sl} + {1'b0, b_eff} + {{SLICE{1'b0}}, carry_r};

   // Operand holding registers need no reset; they are only read after a capture.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_r <= a;
         b_r <= b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         carry_r <= 1'b0;
         sum_r   <= '0;
         cout_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state   <= RUN;
                  cnt     <= '0;
                  carry_r <= preload;
               end
            end
            RUN: begin
               for (int k = 0; k < N; k++) begin
                  if (cnt == CW'(k)) begin
                     sum_r[k*SLICE +: SLICE] <= slice_res[SLICE-1:0];
                  end
               end
               carry_r <= slice_res[SLICE];
               if (last) begin
                  state  <= DONE;
                  cout_r <= slice_res[SLICE];
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH=16, SLICE=4; define SAC_SUB_EN for the subtract build.
module tb_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        cin;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        cout;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder_ctrl #(.WIDTH(16), .SLICE(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands, wait (bounded) for in_ready, pass the accept edge, then scramble inputs.
   task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic c, input logic s);
      int w;
      a = av; b = bv; cin = c; sub = s; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check_val("accept_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'hA5A5; b = 16'h5A5A; cin = ~c; sub = ~s;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("retire_out_valid", out_valid, 0);
      check_val("retire_in_ready", in_ready, 1);
   endtask

   initial begin
      int lat;
      int first;
      int second;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_sum", sum, 0);
      check_val("rst_cout", cout, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("rst_in_ready", in_ready, 1);

      // 1: carry across a slice boundary, latency check
      send(16'h00FF, 16'h0001, 1'b0, 1'b0);
      check_val("t1_in_ready_run", in_ready, 0);
      wait_done(lat);
      check_val("t1_latency", lat, 4);
      check_val("t1_sum", sum, 16'h0100);
      check_val("t1_cout", cout, 0);
      retire();

      // 2: full wrap-around
      send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done(lat);
      check_val("t2_latency", lat, 4);
      check_val("t2_sum", sum, 16'h0000);
      check_val("t2_cout", cout, 1);
      retire();

      // 3: carry-in and backpressure hold
      send(16'h1234, 16'h4321, 1'b1, 1'b0);
      wait_done(lat);
      check_val("t3_latency", lat, 4);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_val("t3_hold_valid", out_valid, 1);
         check_val("t3_hold_sum", sum, 16'h5556);
         check_val("t3_hold_cout", cout, 0);
         check_val("t3_hold_in_ready", in_ready, 0);
      end
      retire();

      // 4: reset during slice 2, then a fresh op
      send(16'h0F0F, 16'h0101, 1'b1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check_val("t4_rst_out_valid", out_valid, 0);
      check_val("t4_rst_sum", sum, 0);
      check_val("t4_rst_cout", cout, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_val("t4_in_ready", in_ready, 1);
      check_val("t4_out_valid", out_valid, 0);
      send(16'h0001, 16'h0002, 1'b0, 1'b0);
      wait_done(lat);
      check_val("t4_latency", lat, 4);
      check_val("t4_sum", sum, 16'h0003);
      retire();

      // 5: in_valid held high with out_ready high; operand change mid-RUN must be ignored
      a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1; out_ready = 1'b1;
      first = -1; second = -1;
      for (int i = 0; i < 20; i++) begin
         if (in_valid && in_ready) begin
            if (first < 0) first = i;
            else if (second < 0) second = i;
         end
         if (first >= 0 && second < 0 && i > first && i <= first + 4)
            check_val("t5_in_ready_run", in_ready, 0);
         if (first >= 0 && i == first + 2) a = 16'h7777;
         if (out_valid && second < 0) check_val("t5_sum", sum, 16'h0303);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      check_val("t5_idle_gap", second - first - 1, 5);
      repeat (10) @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val("t5_drained", in_ready, 1);

      // 6: sub request
      send(16'h0005, 16'h0007, 1'b0, 1'b1);
      wait_done(lat);
      check_val("t6_latency", lat, 4);
`ifdef SAC_SUB_EN
      check_val("t6_sum", sum, 16'hFFFE);
      check_val("t6_cout", cout, 0);
`else
      check_val("t6_sum", sum, 16'h000C);
      check_val("t6_cout", cout, 0);
`endif
      retire();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
